// File: rtl/parity_frame_rx_pkg.sv
// Shared constants for the XOR-parity serial link receiver.
package parity_frame_rx_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 8;
    localparam int unsigned ERR_W          = 8;
    localparam int unsigned FRAME_LEN      = DATA_WIDTH_DEF + 1;

endpackage

// File: rtl/parity_frame_rx_frame_shifter.sv
// Bit counter, LSB-first deserializer and running XOR for one parity frame.
module frame_shifter
    import parity_frame_rx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  accept,
    input  logic                  resync,
    input  logic                  bit_in,
    output logic                  parity_phase_c,
    output logic                  frame_done_c,
    output logic [DATA_WIDTH-1:0] word_c,
    output logic                  parity_err_c
);

    localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);

    logic [CNT_W-1:0]      cnt_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  acc_q;

    assign parity_phase_c = (cnt_q == CNT_W'(DATA_WIDTH));
    assign frame_done_c   = accept & !resync & parity_phase_c;
    assign word_c         = shift_q;
    assign parity_err_c   = acc_q ^ bit_in;

    // resync takes priority over any bit presented in the same cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q   <= '0;
            shift_q <= '0;
            acc_q   <= 1'b0;
        end else if (resync) begin
            cnt_q <= '0;
            acc_q <= 1'b0;
        end else if (accept) begin
            if (parity_phase_c) begin
                cnt_q <= '0;
                acc_q <= 1'b0;
            end else begin
                shift_q <= (shift_q & ~(DATA_WIDTH'(1) << cnt_q))
                         | (DATA_WIDTH'(bit_in) << cnt_q);
                acc_q   <= acc_q ^ bit_in;
                cnt_q   <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/parity_frame_rx.sv
// XOR-parity frame receiver: deserializer plus single-entry ready/valid holding register.
module parity_frame_rx
    import parity_frame_rx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  bit_in,
    input  logic                  bit_valid,
    output logic                  bit_ready,
    input  logic                  resync,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_parity_err,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ERR_W-1:0]      err_count
);

    logic                  parity_phase_c;
    logic                  frame_done_c;
    logic [DATA_WIDTH-1:0] word_c;
    logic                  parity_err_c;
    logic                  accept_c;

    // Stall only the parity bit, and only when its word would overwrite an unread one
    assign bit_ready = !(parity_phase_c & out_valid & !out_ready);
    assign accept_c  = bit_valid & bit_ready;

    frame_shifter #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_shifter (
        .clock          (clock),
        .reset          (reset),
        .accept         (accept_c),
        .resync         (resync),
        .bit_in         (bit_in),
        .parity_phase_c (parity_phase_c),
        .frame_done_c   (frame_done_c),
        .word_c         (word_c),
        .parity_err_c   (parity_err_c)
    );

    // Holding register: a completing frame wins over a consume in the same cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            out_data       <= '0;
            out_parity_err <= 1'b0;
            out_valid      <= 1'b0;
            err_count      <= '0;
        end else if (frame_done_c) begin
            out_data       <= word_c;
            out_parity_err <= parity_err_c;
            out_valid      <= 1'b1;
            if (parity_err_c && (err_count != '1)) begin
                err_count <= err_count + ERR_W'(1);
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_parity_frame_rx.sv
// Directed self-checking bench for parity_frame_rx.
module tb_parity_frame_rx;

    logic       clock = 1'b0;
    logic       reset;
    logic       bit_in;
    logic       bit_valid;
    logic       bit_ready;
    logic       resync;
    logic [7:0] out_data;
    logic       out_parity_err;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] err_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    parity_frame_rx #(.DATA_WIDTH(8)) dut (
        .clock          (clock),
        .reset          (reset),
        .bit_in         (bit_in),
        .bit_valid      (bit_valid),
        .bit_ready      (bit_ready),
        .resync         (resync),
        .out_data       (out_data),
        .out_parity_err (out_parity_err),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .err_count      (err_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bit_valid = 1'b1;
        bit_in    = b;
        tick();
        bit_valid = 1'b0;
        bit_in    = 1'b0;
    endtask

    task automatic send_data(input logic [7:0] w, input int nbits);
        for (int i = 0; i < nbits; i++) send_bit(w[i]);
    endtask

    task automatic idle();
        bit_valid = 1'b0;
        tick();
    endtask

    initial begin
        reset     = 1'b1;
        bit_in    = 1'b0;
        bit_valid = 1'b0;
        resync    = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_data", 32'(out_data), 32'h0);
        check("rst_perr", 32'(out_parity_err), 32'h0);
        check("rst_errcnt", 32'(err_count), 32'h0);
        check("rst_ready", 32'(bit_ready), 32'h1);

        // good frame 0xA5, even parity 0
        out_ready = 1'b1;
        send_data(8'hA5, 8);
        check("a5_valid_before_parity", 32'(out_valid), 32'h0);
        send_bit(1'b0);
        check("a5_valid", 32'(out_valid), 32'h1);
        check("a5_data", 32'(out_data), 32'hA5);
        check("a5_perr", 32'(out_parity_err), 32'h0);
        check("a5_errcnt", 32'(err_count), 32'h0);
        idle();
        check("a5_consumed", 32'(out_valid), 32'h0);

        // 0x07 has odd weight, parity 0 is wrong
        send_data(8'h07, 8);
        send_bit(1'b0);
        check("07_data", 32'(out_data), 32'h07);
        check("07_perr", 32'(out_parity_err), 32'h1);
        check("07_errcnt", 32'(err_count), 32'h1);
        idle();

        // backpressure: 0x11 held while 0x22 waits at its parity bit
        out_ready = 1'b0;
        send_data(8'h11, 8);
        send_bit(1'b0);
        check("11_valid", 32'(out_valid), 32'h1);
        check("11_data", 32'(out_data), 32'h11);
        send_data(8'h22, 8);
        check("22_ready_low", 32'(bit_ready), 32'h0);
        send_bit(1'b0);
        check("22_stall_data", 32'(out_data), 32'h11);
        check("22_stall_ready", 32'(bit_ready), 32'h0);
        bit_valid = 1'b1;
        bit_in    = 1'b0;
        out_ready = 1'b1;
        #1;
        check("22_ready_comb", 32'(bit_ready), 32'h1);
        tick();
        bit_valid = 1'b0;
        check("22_valid_kept", 32'(out_valid), 32'h1);
        check("22_data", 32'(out_data), 32'h22);
        check("22_perr", 32'(out_parity_err), 32'h0);
        check("22_errcnt", 32'(err_count), 32'h1);
        idle();
        check("22_consumed", 32'(out_valid), 32'h0);

        // resync after 3 bits, with a bit presented the same cycle
        send_data(8'hFF, 3);
        resync    = 1'b1;
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        tick();
        resync    = 1'b0;
        bit_valid = 1'b0;
        check("resync_valid", 32'(out_valid), 32'h0);
        send_data(8'h3C, 8);
        check("3c_valid_before_parity", 32'(out_valid), 32'h0);
        send_bit(1'b0);
        check("3c_data", 32'(out_data), 32'h3C);
        check("3c_perr", 32'(out_parity_err), 32'h0);
        check("3c_errcnt", 32'(err_count), 32'h1);

        // reset mid-frame with a word still held
        out_ready = 1'b0;
        send_data(8'hFF, 5);
        check("pre_rst_valid", 32'(out_valid), 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_valid", 32'(out_valid), 32'h0);
        check("mid_rst_data", 32'(out_data), 32'h0);
        check("mid_rst_errcnt", 32'(err_count), 32'h0);
        check("mid_rst_ready", 32'(bit_ready), 32'h1);
        out_ready = 1'b1;
        send_data(8'h81, 8);
        send_bit(1'b0);
        check("81_data", 32'(out_data), 32'h81);
        check("81_perr", 32'(out_parity_err), 32'h0);
        check("81_errcnt", 32'(err_count), 32'h0);

        // back-to-back bad frames drive err_count to saturation
        for (int f = 0; f < 260; f++) begin
            send_data(8'h01, 8);
            send_bit(1'b0);
            if (f == 253) check("errcnt_254", 32'(err_count), 32'd254);
            if (f == 254) check("errcnt_255", 32'(err_count), 32'd255);
        end
        check("errcnt_sat", 32'(err_count), 32'd255);
        check("sat_perr", 32'(out_parity_err), 32'h1);
        check("sat_data", 32'(out_data), 32'h01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/parity_frame_rx.md
# parity_frame_rx

Receive side of the XOR-parity serial link. Accepts a bit-serial stream of frames (DATA_WIDTH data bits LSB-first, then one even-parity bit produced by the XOR-reduction transmitter). Deserializes each frame, checks parity, and presents the word on a ready/valid output with a single-entry holding register. It sits between the link's bit-level input and the word-level consumer, and keeps a saturating parity-error counter for status readout.

## Interface
- DATA_WIDTH, 8: data bits per frame (≥1); frame length is DATA_WIDTH+1 bits.
- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- bit_in  in  1  serial bit.
- bit_valid  in  1  bit_in is presented this cycle.
- bit_ready  out  1  bit accepted when bit_valid & bit_ready.
- resync  in  1  discard partial frame and restart at data bit 0.
- out_data  out  DATA_WIDTH  received word.
- out_parity_err  out  1  XOR of data bits and parity bit was 1.
- out_valid  out  1  holding register occupied.
- out_ready  in  1  consumer accepts when out_valid & out_ready.
- err_count  out  8  saturating count of frames with parity error.

## Operation
- Bit counter cnt in 0..DATA_WIDTH; cnt<DATA_WIDTH = data phase, cnt==DATA_WIDTH = parity phase.
- Data phase accept: shift bit into shift register at position cnt (LSB first); acc ^= bit_in; cnt++.
- Parity phase accept: load out_data←shift register, out_parity_err←acc^bit_in; out_valid←1; err_count += parity_err (saturate at 255); cnt←0, acc←0.
- bit_ready = !(cnt==DATA_WIDTH & out_valid & !out_ready); low only when completing a frame would overwrite an unconsumed word. Data-phase bits are always accepted.
- Output consumed (out_valid & out_ready) with no frame completion that cycle: out_valid←0.
- Consume and frame completion in the same cycle: new word loaded, out_valid stays 1.
- out_data/out_parity_err held stable while out_valid & !out_ready.
- resync: cnt←0, acc←0, shift register unaffected/irrelevant; holding register, out_valid and err_count untouched. resync and bit_valid together: resync wins, bit discarded, bit_ready value irrelevant.
- reset: cnt←0, acc←0, shift register 0, out_data 0, out_parity_err 0, out_valid 0, err_count 0. Reset mid-frame discards the partial frame.

## Timing
- Reset values: out_valid 0, out_data 0, out_parity_err 0, err_count 0; bit_ready 1 the cycle after reset.
- Latency: out_valid and err_count update one cycle after the accepting edge of the parity bit.
- bit_ready is combinational from out_ready; no other combinational input→output paths.
- Sustained throughput: one bit per cycle with out_ready high; no bubble between frames.

## Structure
- Shared package: DATA_WIDTH default constant, err_count width (8) constant, frame length constant DATA_WIDTH+1.
- One sub-module, frame_shifter: counter, shift register, XOR accumulator; outputs frame-complete pulse, word and parity result. Top level holds the output register, handshake and err_count.

## Test plan
- 0xA5 LSB-first then parity 0, out_ready=1 → out_data=0xA5, out_parity_err=0, out_valid one cycle after parity bit, err_count=0.
- 0x07 with parity 0 → out_parity_err=1, err_count=1.
- out_ready=0, frame 0x11/p0 then 0x22/p0 back-to-back → bit_ready drops at the second frame's parity bit, out_data stays 0x11; raise out_ready → 0x11 consumed, 0x22 accepted same cycle, out_valid stays 1, then 0x22 presented.
- Three bits then resync (with bit_valid=1 same cycle), then 0x3C/p0 → out_data=0x3C, err_count unchanged.
- Reset asserted after 5 bits of a frame → all outputs 0; next full frame 0x81/p0 decodes correctly.
- 260 consecutive bad-parity frames → err_count saturates at 255.
